// File: rtl/led_pkg.sv
// led_pkg: shared types and defaults for the LED divider sequencer slice.
// Rev 1.0
`default_nettype none

package led_pkg;

  localparam int DIV_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    STEP  = 2'd3
  } led_seq_st_t;

  typedef struct packed {
    logic [DIV_W_DEF-1:0] start;
    logic [DIV_W_DEF-1:0] stop;
    logic [DIV_W_DEF-1:0] step;
    logic                 loop;
  } led_seq_cmd_t;

endpackage

`default_nettype wire

// File: rtl/led_div_seq_if.sv
// led_div_seq_if: ramp command, abort and counter-write bundle of led_div_seq.
// Rev 1.0
`default_nettype none

interface led_div_seq_if
  import led_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
);

  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [DIV_W-1:0] cmd_start_i;
  logic [DIV_W-1:0] cmd_stop_i;
  logic [DIV_W-1:0] cmd_step_i;
  logic             cmd_loop_i;
  logic             abort_i;
  logic [DIV_W-1:0] div_o;
  logic             wren_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output cmd_valid_i, cmd_start_i, cmd_stop_i, cmd_step_i, cmd_loop_i, abort_i,
    input  cmd_ready_o, div_o, wren_o, busy_o, done_o
  );

  modport slave (
    input  cmd_valid_i, cmd_start_i, cmd_stop_i, cmd_step_i, cmd_loop_i, abort_i,
    output cmd_ready_o, div_o, wren_o, busy_o, done_o
  );

endinterface

`default_nettype wire

// File: rtl/led_dwell_tmr.sv
// led_dwell_tmr: loadable down-counter; expire_o is high while the count sits at zero.
// Rev 1.0
`default_nettype none

module led_dwell_tmr #(
  parameter int DWELL_W = 24
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               load_i,
  input  wire logic [DWELL_W-1:0] load_val_i,
  output logic                    expire_o
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (cnt != '0) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign expire_o = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/led_div_seq.sv
// led_div_seq: paced divider ramp writer for the LED counter; build option
// LED_DIV_SEQ_BOUNCE_EN makes loop mode ping-pong between the endpoints. Rev 1.0
`default_nettype none

module led_div_seq
  import led_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int DWELL_CYC = 10_000_000,
  parameter int DWELL_W   = 24
) (
  input wire logic     clk100,
  input wire logic     rst,
  led_div_seq_if.slave bus
);

  // The write cycle itself counts toward the dwell, so the timer covers DWELL_CYC-1 cycles.
  localparam logic [DWELL_W-1:0] DWELL_LD  = (DWELL_CYC >= 2) ? DWELL_W'(DWELL_CYC - 2) : '0;
  localparam bit                 DWELL_ONE = (DWELL_CYC == 1);

  led_seq_st_t      state, state_nxt;
  logic [DIV_W-1:0] start_val, stop_val, step_val, div;
  logic             loop_en, ascend, at_last, wren, done;
  logic             ready, accept, expire, tmr_load, dwell_done;
  logic             go_load, go_step, one_shot_end, bounce;
  logic             dir_up, nxt_last;
  logic [DIV_W-1:0] target, nxt_val;
  logic [DIV_W:0]   nxt_ext;

  led_dwell_tmr #(.DWELL_W(DWELL_W)) u_tmr (
    .clk        (clk100),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (DWELL_LD),
    .expire_o   (expire)
  );

  // Next point in DIV_W+1 bits: overshoot in either direction clamps to the target.
  always_comb begin
    bounce = 1'b0;
    dir_up = ascend;
    target = stop_val;
`ifdef LED_DIV_SEQ_BOUNCE_EN
    if (at_last && loop_en && (start_val != stop_val)) begin
      bounce = 1'b1;
      dir_up = ~ascend;
      target = start_val;
    end
`endif
    if (dir_up) begin
      nxt_ext  = {1'b0, div} + {1'b0, step_val};
      nxt_last = (nxt_ext >= {1'b0, target});
    end else begin
      nxt_ext  = {1'b0, div} - {1'b0, step_val};
      nxt_last = ($signed(nxt_ext) <= $signed({1'b0, target}));
    end
    nxt_val = nxt_last ? target : nxt_ext[DIV_W-1:0];
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ready        = (state == IDLE) && !rst && !done;
    accept       = 1'b0;
    tmr_load     = 1'b0;
    dwell_done   = 1'b0;
    go_load      = 1'b0;
    go_step      = 1'b0;
    one_shot_end = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid_i && ready) begin
          accept    = 1'b1;
          go_load   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD, STEP: begin
        tmr_load   = 1'b1;
        dwell_done = DWELL_ONE;
        state_nxt  = DWELL;
      end
      DWELL:   dwell_done = expire;
      default: state_nxt = IDLE;
    endcase
    if (dwell_done) begin
      if (!at_last || bounce) begin
        go_step   = 1'b1;
        state_nxt = STEP;
      end else if (loop_en) begin
        go_load   = 1'b1;
        state_nxt = LOAD;
      end else begin
        one_shot_end = 1'b1;
        state_nxt    = IDLE;
      end
    end
    if ((state != IDLE) && bus.abort_i) begin
      go_load      = 1'b0;
      go_step      = 1'b0;
      one_shot_end = 1'b0;
      state_nxt    = IDLE;
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      start_val <= '0;
      stop_val  <= '0;
      step_val  <= '0;
      loop_en   <= 1'b0;
      ascend    <= 1'b0;
      at_last   <= 1'b0;
      div       <= '0;
      wren      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wren <= go_load || go_step;
      done <= one_shot_end;
      if (accept) begin
        start_val <= bus.cmd_start_i;
        stop_val  <= bus.cmd_stop_i;
        step_val  <= (bus.cmd_step_i == '0) ? DIV_W'(1) : bus.cmd_step_i;
        loop_en   <= bus.cmd_loop_i;
        ascend    <= (bus.cmd_start_i <= bus.cmd_stop_i);
        div       <= bus.cmd_start_i;
        at_last   <= (bus.cmd_start_i == bus.cmd_stop_i);
      end else if (go_load) begin
        div     <= start_val;
        at_last <= (start_val == stop_val);
      end else if (go_step) begin
        div     <= nxt_val;
        at_last <= nxt_last;
`ifdef LED_DIV_SEQ_BOUNCE_EN
        if (bounce) begin
          start_val <= stop_val;
          stop_val  <= start_val;
          ascend    <= ~ascend;
        end
`endif
      end
    end
  end

  assign bus.cmd_ready_o = ready;
  assign bus.div_o       = div;
  assign bus.wren_o      = wren;
  assign bus.busy_o      = (state != IDLE);
  assign bus.done_o      = done;

endmodule

`default_nettype wire

// File: tb/tb_led_div_seq.sv
// tb_led_div_seq: directed ramp scenarios against a queue of expected writes (DWELL_CYC = 4).
`default_nettype none

module tb_led_div_seq;
  import led_pkg::*;

  logic clk100;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [11:0] exp_q[$];

  led_div_seq_if #(.DIV_W(12)) bus ();

  led_div_seq #(.DIV_W(12), .DWELL_CYC(4), .DWELL_W(24)) dut (
    .clk100 (clk100),
    .rst    (rst),
    .bus    (bus)
  );

  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input led_seq_cmd_t c);
    check("ready_idle", bus.cmd_ready_o, 1);
    bus.cmd_start_i = c.start;
    bus.cmd_stop_i  = c.stop;
    bus.cmd_step_i  = c.step;
    bus.cmd_loop_i  = c.loop;
    bus.cmd_valid_i = 1'b1;
    @(negedge clk100);
    // Scramble the fields so a design that fails to capture them shows it.
    bus.cmd_valid_i = 1'b0;
    bus.cmd_start_i = 12'hABC;
    bus.cmd_stop_i  = 12'h123;
    bus.cmd_step_i  = 12'h7;
    bus.cmd_loop_i  = ~c.loop;
  endtask

  // Samples cycles T+1..T+ncyc after accept; pops a queue entry per write.
  task automatic watch(input int ncyc, input bit want_done, input int abort_at, input int poke_at);
    int gap = 1;
    bit first = 1'b1;
    int done_cnt = 0;
    int done_k = -10;
    int done_gap = -1;
    logic [11:0] e;
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) gap++;
      if (bus.wren_o) begin
        if (exp_q.size() == 0) begin
          check("extra_wren", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("div", bus.div_o, e);
          check("wr_gap", gap, first ? 1 : 4);
        end
        first = 1'b0;
        gap   = 0;
      end
      if (k == 2) begin
        check("busy_run", bus.busy_o, 1);
        check("ready_run", bus.cmd_ready_o, 0);
      end
      if (k == done_k + 1) check("ready_after_done", bus.cmd_ready_o, 1);
      if (abort_at > 0 && k == abort_at + 1) begin
        check("busy_after_abort", bus.busy_o, 0);
        check("ready_after_abort", bus.cmd_ready_o, 1);
      end
      if (bus.done_o) begin
        done_cnt++;
        done_k   = k;
        done_gap = gap;
        check("busy_at_done", bus.busy_o, 0);
        check("ready_at_done", bus.cmd_ready_o, 0);
      end
      bus.abort_i     = (k == abort_at);
      bus.cmd_valid_i = (k == poke_at);
      if (k == poke_at) bus.cmd_start_i = 12'd999;
      @(negedge clk100);
    end
    bus.abort_i     = 1'b0;
    bus.cmd_valid_i = 1'b0;
    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_cnt, want_done ? 1 : 0);
    if (want_done) check("done_gap", done_gap, 4);
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_start_i = '0;
    bus.cmd_stop_i  = '0;
    bus.cmd_step_i  = '0;
    bus.cmd_loop_i  = 1'b0;
    bus.abort_i     = 1'b0;

    // Reset held for three cycles
    @(negedge clk100);
    for (int i = 0; i < 3; i++) begin
      check("rst_outs", {bus.div_o, bus.wren_o, bus.busy_o, bus.done_o, bus.cmd_ready_o}, 0);
      @(negedge clk100);
    end
    rst = 1'b0;
    @(negedge clk100);
    check("ready_after_rst", bus.cmd_ready_o, 1);

    // Ascending one-shot
    exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(30); exp_q.push_back(40);
    send_cmd('{start: 12'd10, stop: 12'd40, step: 12'd10, loop: 1'b0});
    watch(20, 1'b1, 0, 0);
    check("div_hold", bus.div_o, 40);

    // Descending with clamp
    exp_q.push_back(100); exp_q.push_back(60); exp_q.push_back(20); exp_q.push_back(5);
    send_cmd('{start: 12'd100, stop: 12'd5, step: 12'd40, loop: 1'b0});
    watch(19, 1'b1, 0, 0);

    // Top-of-range ascent must not wrap
    exp_q.push_back(4090); exp_q.push_back(4095);
    send_cmd('{start: 12'd4090, stop: 12'd4095, step: 12'd4000, loop: 1'b0});
    watch(11, 1'b1, 0, 0);

    // Step 0 behaves as step 1
    exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5);
    send_cmd('{start: 12'd3, stop: 12'd5, step: 12'd0, loop: 1'b0});
    watch(15, 1'b1, 0, 0);

    // Abort two cycles after the second write; a command poked while busy is ignored
    exp_q.push_back(0); exp_q.push_back(10);
    send_cmd('{start: 12'd0, stop: 12'd40, step: 12'd10, loop: 1'b0});
    watch(16, 1'b0, 7, 3);
    check("div_after_abort", bus.div_o, 10);

    // Loop mode, aborted in the cycle of the seventh write
`ifdef LED_DIV_SEQ_BOUNCE_EN
    exp_q.push_back(0); exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(10);
    exp_q.push_back(0); exp_q.push_back(10); exp_q.push_back(20);
`else
    exp_q.push_back(0); exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(0);
    exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(0);
`endif
    send_cmd('{start: 12'd0, stop: 12'd20, step: 12'd10, loop: 1'b1});
    watch(32, 1'b0, 25, 0);

    // Single point
    exp_q.push_back(7);
    send_cmd('{start: 12'd7, stop: 12'd7, step: 12'd3, loop: 1'b0});
    watch(7, 1'b1, 0, 0);

    // Reset during the dwell of a long ramp
    exp_q.push_back(0); exp_q.push_back(1);
    send_cmd('{start: 12'd0, stop: 12'd4095, step: 12'd1, loop: 1'b0});
    watch(6, 1'b0, 0, 0);
    rst = 1'b1;
    @(negedge clk100);
    check("rst_mid_outs", {bus.div_o, bus.wren_o, bus.busy_o, bus.done_o, bus.cmd_ready_o}, 0);
    rst = 1'b0;
    @(negedge clk100);
    check("ready_after_rst2", bus.cmd_ready_o, 1);
    check("no_wren_after_rst", bus.wren_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
